// File: rtl/accel_spi_pkg.sv
// rtl/accel_spi_pkg.sv - ADXL362 register map constants, FSM states and helpers (ACCEL_RESP_STATUS_EN adds STATUS/INTMAP1)
package accel_spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_REVID     = 6'h03;
  localparam logic [5:0] ADDR_XDATA     = 6'h08;
  localparam logic [5:0] ADDR_YDATA     = 6'h09;
  localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
  localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
  localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
`ifdef ACCEL_RESP_STATUS_EN
  localparam logic [5:0] ADDR_STATUS    = 6'h0B;
`endif

  localparam logic [7:0] DEVID_AD_VAL  = 8'hAD;
  localparam logic [7:0] DEVID_MST_VAL = 8'h1D;
  localparam logic [7:0] PARTID_VAL    = 8'hF2;
  localparam logic [7:0] REVID_VAL     = 8'h01;

  // Writable window 0x1F..0x2E; storage index is addr[3:0]+1, mapping it onto 0..15
  localparam logic [5:0] WR_ADDR_LO = 6'h1F;
  localparam logic [5:0] WR_ADDR_HI = 6'h2E;
  localparam int         NUM_CTRL   = 16;
  localparam logic [3:0] FILTER_CTL_IDX = 4'hD;  // 0x2C
  localparam logic [3:0] POWER_CTL_IDX  = 4'hE;  // 0x2D
`ifdef ACCEL_RESP_STATUS_EN
  localparam logic [3:0] INTMAP1_IDX    = 4'hB;  // 0x2A
`endif

  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_DROP
  } state_t;

  function automatic logic is_writable(input logic [5:0] a);
    return (a >= WR_ADDR_LO) && (a <= WR_ADDR_HI);
  endfunction

  function automatic logic [7:0] ctrl_reset_value(input logic [3:0] idx);
    return (idx == FILTER_CTL_IDX) ? FILTER_CTL_RST : 8'h00;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-flop synchronizer with a third flop for rise/fall detection
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3;

  // Synchronize the pin and keep one delayed copy for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= RESET_VAL;
      r_s2 <= RESET_VAL;
      r_s3 <= RESET_VAL;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/accel_spi_responder.sv
// rtl/accel_spi_responder.sv - ADXL362 SPI register emulator (ACCEL_RESP_STATUS_EN adds STATUS.DATA_READY and int1)
module accel_spi_responder
  import accel_spi_pkg::*;
(
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  output logic        miso,
  input  logic [15:0] x_data,
  input  logic [15:0] y_data,
  input  logic [15:0] z_data,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data
`ifdef ACCEL_RESP_STATUS_EN
  ,
  output logic        int1
`endif
);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic r_mosi_s1, r_mosi_s2;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_tx;
  logic [5:0]  r_addr;
  logic        r_is_read;
  logic        r_miso;
  logic        r_wr_strobe;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_soft_pend;
  logic [7:0]  r_ctrl [NUM_CTRL];

  logic [15:0] r_px, r_py, r_pz, r_x, r_y, r_z;
  logic        r_pend;
`ifdef ACCEL_RESP_STATUS_EN
  logic        r_data_ready;
  logic        w_rd_clear;
`endif

  logic [7:0]  w_byte;
  logic [5:0]  w_rd_addr;
  logic [3:0]  w_rd_idx;
  logic [3:0]  w_wr_idx;
  logic [7:0]  w_rd_data;
  logic        w_xfer;

  spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .i_clk(CLK100MHZ), .i_rst_n(rst_n), .i_async(sclk),
    .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_edge_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .i_clk(CLK100MHZ), .i_rst_n(rst_n), .i_async(cs),
    .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // MOSI needs only the 2-flop path; it lines up with the sclk edge detector
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_byte    = {r_rx, r_mosi_s2};
  assign w_rd_addr = (r_state == ST_ADDR) ? w_byte[5:0] : r_addr + 6'd1;
  assign w_rd_idx  = w_rd_addr[3:0] + 4'd1;
  assign w_wr_idx  = r_addr[3:0] + 4'd1;
  // Only move samples to the visible set between transactions so a read stays coherent
  assign w_xfer    = r_pend && (r_state == ST_IDLE) && !w_cs_fall;

  // Register read mux for the byte about to be loaded into the MISO shifter
  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      ADDR_DEVID_AD:  w_rd_data = DEVID_AD_VAL;
      ADDR_DEVID_MST: w_rd_data = DEVID_MST_VAL;
      ADDR_PARTID:    w_rd_data = PARTID_VAL;
      ADDR_REVID:     w_rd_data = REVID_VAL;
      ADDR_XDATA:     w_rd_data = r_x[11:4];
      ADDR_YDATA:     w_rd_data = r_y[11:4];
      ADDR_ZDATA:     w_rd_data = r_z[11:4];
      ADDR_XDATA_L:   w_rd_data = r_x[7:0];
      ADDR_XDATA_H:   w_rd_data = r_x[15:8];
      ADDR_YDATA_L:   w_rd_data = r_y[7:0];
      ADDR_YDATA_H:   w_rd_data = r_y[15:8];
      ADDR_ZDATA_L:   w_rd_data = r_z[7:0];
      ADDR_ZDATA_H:   w_rd_data = r_z[15:8];
`ifdef ACCEL_RESP_STATUS_EN
      ADDR_STATUS:    w_rd_data = {7'd0, r_data_ready};
`endif
      default: begin
        if (is_writable(w_rd_addr) && (w_rd_addr != ADDR_SOFT_RESET))
          w_rd_data = r_ctrl[w_rd_idx];
      end
    endcase
  end

  // Transaction FSM: byte assembly, register writes, MISO shifting and soft reset
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_addr      <= 6'd0;
      r_is_read   <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 6'd0;
      r_wr_data   <= 8'd0;
      r_soft_pend <= 1'b0;
      for (int i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= ctrl_reset_value(4'(i));
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
        if (r_soft_pend) begin
          r_soft_pend <= 1'b0;
          for (int i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= ctrl_reset_value(4'(i));
        end
      end else if (r_state == ST_IDLE) begin
        if (w_cs_fall) begin
          r_state   <= ST_CMD;
          r_bit_cnt <= 3'd0;
        end
      end else if (w_sclk_rise) begin
        r_rx      <= w_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          case (r_state)
            ST_CMD: begin
              if (w_byte == CMD_WRITE) begin
                r_state   <= ST_ADDR;
                r_is_read <= 1'b0;
              end else if (w_byte == CMD_READ) begin
                r_state   <= ST_ADDR;
                r_is_read <= 1'b1;
              end else begin
                r_state   <= ST_DROP;
              end
            end
            ST_ADDR: begin
              r_addr <= w_byte[5:0];
              if (r_is_read) begin
                r_state <= ST_RDATA;
                r_tx    <= w_rd_data;
              end else begin
                r_state <= ST_WDATA;
              end
            end
            ST_WDATA: begin
              if (is_writable(r_addr)) begin
                r_ctrl[w_wr_idx] <= w_byte;
                r_wr_strobe      <= 1'b1;
                r_wr_addr        <= r_addr;
                r_wr_data        <= w_byte;
                if ((r_addr == ADDR_SOFT_RESET) && (w_byte == SOFT_RESET_KEY))
                  r_soft_pend <= 1'b1;
              end
              r_addr <= r_addr + 6'd1;
            end
            ST_RDATA: begin
              r_addr <= r_addr + 6'd1;
              r_tx   <= w_rd_data;
            end
            default: ;
          endcase
        end
      end else if (w_sclk_fall && (r_state == ST_RDATA)) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

`ifdef ACCEL_RESP_STATUS_EN
  assign w_rd_clear = w_sclk_rise && !w_cs_rise && (r_bit_cnt == 3'd7) &&
                      (((r_state == ST_ADDR) && r_is_read) || (r_state == ST_RDATA)) &&
                      ((w_rd_addr == ADDR_XDATA) || (w_rd_addr == ADDR_XDATA_L));
`endif

  // Sample capture into the pending buffer and transfer to the visible registers
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_px <= 16'd0; r_py <= 16'd0; r_pz <= 16'd0;
      r_x  <= 16'd0; r_y  <= 16'd0; r_z  <= 16'd0;
      r_pend <= 1'b0;
`ifdef ACCEL_RESP_STATUS_EN
      r_data_ready <= 1'b0;
`endif
    end else begin
      if (w_xfer) begin
        r_x <= r_px;
        r_y <= r_py;
        r_z <= r_pz;
      end
      if (sample_valid) begin
        r_px   <= x_data;
        r_py   <= y_data;
        r_pz   <= z_data;
        r_pend <= 1'b1;
      end else if (w_xfer) begin
        r_pend <= 1'b0;
      end
`ifdef ACCEL_RESP_STATUS_EN
      if (w_xfer)          r_data_ready <= 1'b1;
      else if (w_rd_clear) r_data_ready <= 1'b0;
`endif
    end
  end

  assign miso      = r_miso;
  assign power_ctl = r_ctrl[POWER_CTL_IDX];
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
`ifdef ACCEL_RESP_STATUS_EN
  assign int1      = r_data_ready & r_ctrl[INTMAP1_IDX][0];
`endif

endmodule
